// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, compare sub-modes and FSM state encoding for alu_pipe
// Purpose: single source for the ALU_control / bonus_control encodings and the
//          IDLE/MUL state type used by alu_pipe and alu_mul_iter.
// Ports:   none (package).
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_CMP  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  localparam logic [2:0] CMP_LT = 3'b000;
  localparam logic [2:0] CMP_LE = 3'b001;
  localparam logic [2:0] CMP_NE = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b011;
  localparam logic [2:0] CMP_GT = 3'b110;
  localparam logic [2:0] CMP_GE = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier, one multiplier bit per cycle
// Purpose: computes a_i * b_i as a 2*WIDTH product over WIDTH cycles after start_i.
// Ports:   clk, rst_n      clock / async active-low reset
//          start_i         load operands (one-cycle pulse)
//          a_i, b_i        WIDTH-bit multiplicand / multiplier
//          done_o          high in the cycle the final step is taken
//          product_o       2*WIDTH product, valid while done_o is high
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               active_q, active_d;
  logic [2*WIDTH-1:0] step_sum;

  always_comb begin
    step_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_o   = 1'b0;
    if (start_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = CW'(WIDTH);
      active_d = 1'b1;
    end else if (active_q) begin
      prod_d   = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      // The last step's sum is handed out combinationally so the caller can
      // register it on the same edge the multiplier goes idle.
      if (cnt_q == CW'(1)) begin
        done_o   = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  assign product_o = step_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered result/flags and iterative multiply
// Purpose: accepts one op per in_valid/in_ready transfer, returns result and flags
//          through a one-entry output register on out_valid/out_ready.
// Ports:   clk, rst_n                     clock / async active-low reset
//          in_valid, in_ready             input channel handshake
//          src1, src2                     WIDTH-bit operands
//          ALU_control, bonus_control     op select / compare sub-mode
//          out_valid, out_ready           output channel handshake
//          result, zero, cout, overflow   registered result and flags
//          busy                           multiply in progress
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  input  logic [2:0]       bonus_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  alu_state_e         state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic               cmp_lt, cmp_eq, cmp_bit;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cout, alu_ovf, alu_legal;

  // Same-cycle drain+accept: a result leaving this cycle frees the single entry.
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign add_sum  = {1'b0, src1} + {1'b0, src2};
  // src1 + ~src2 + 1: bit WIDTH is the no-borrow flag (src1 >= src2 unsigned).
  assign sub_diff = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    if (SIGNED_CMP) cmp_lt = $signed(src1) < $signed(src2);
    else            cmp_lt = src1 < src2;
  end
  assign cmp_eq = (src1 == src2);

  always_comb begin
    alu_res   = '0;
    alu_cout  = 1'b0;
    alu_ovf   = 1'b0;
    alu_legal = 1'b1;
    cmp_bit   = 1'b0;
    case (ALU_control)
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_NOR:  alu_res = ~(src1 | src2);
      OP_NAND: alu_res = ~(src1 & src2);
      OP_ADD: begin
        alu_res  = add_sum[WIDTH-1:0];
        alu_cout = add_sum[WIDTH];
        alu_ovf  = (src1[WIDTH-1] == src2[WIDTH-1]) && (add_sum[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res  = sub_diff[WIDTH-1:0];
        alu_cout = sub_diff[WIDTH];
        alu_ovf  = (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_diff[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_CMP: begin
        case (bonus_control)
          CMP_LT:  cmp_bit = cmp_lt;
          CMP_LE:  cmp_bit = cmp_lt || cmp_eq;
          CMP_NE:  cmp_bit = !cmp_eq;
          CMP_EQ:  cmp_bit = cmp_eq;
          CMP_GE:  cmp_bit = !cmp_lt;
          CMP_GT:  cmp_bit = !(cmp_lt || cmp_eq);
          default: cmp_bit = 1'b0;
        endcase
        alu_res = {{(WIDTH-1){1'b0}}, cmp_bit};
      end
      OP_MUL:  alu_res = '0;
      // Unknown codes complete in one cycle with result and every flag cleared.
      default: alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mul_start   = 1'b0;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ALU_control == OP_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = alu_legal && (alu_res == '0);
            cout_d      = alu_cout;
            ovf_d       = alu_ovf;
          end
        end
      end
      ST_MUL: begin
        // The output entry was drained at accept, so it is free here.
        if (mul_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_prod[WIDTH-1:0];
          zero_d      = (mul_prod[WIDTH-1:0] == '0);
          cout_d      = 1'b0;
          ovf_d       = |mul_prod[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (src1),
    .b_i       (src2),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == ST_MUL);

endmodule
